bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock.
Sits directly upstream of the 4-bit BCD-to-7-segment decoder stage. Each 4-bit digit of its output drives one decoder instance's data_bin input.
Uses a start/busy/done handshake, so a controller can request a conversion and know exactly when the digits are valid.

---
 rtl/bin_to_bcd_seq_pkg.sv | 13 +
 rtl/bin_to_bcd_seq_if.sv | 29 ++
 rtl/bin_to_bcd_seq_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 94 +++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  localparam int unsigned BCD_ADJ_THRESHOLD = 5;
  localparam int unsigned BCD_ADJ_ADD       = 3;
  localparam int unsigned BCD_DIGIT_W       = 4;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus between a controller and the converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned DIGITS      = 3
);

  logic                                             start;
  logic [INPUT_WIDTH-1:0]                           data_in;
  logic                                             busy;
  logic                                             done;
  logic [bin_to_bcd_seq_pkg::BCD_DIGIT_W*DIGITS-1:0] bcd_out;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output bcd_out
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // 5..9 maps to 8..12, so the 4-bit add cannot overflow.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESHOLD)) begin
      digit_o = digit_i + BCD_DIGIT_W'(BCD_ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one operand bit per clock.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned DIGITS      = 3
) (
  input  logic             clk,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned CntW = $clog2(INPUT_WIDTH + 1);
  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] bin_q, bin_d;
  logic [BcdW-1:0]        scr_q, scr_d;
  logic [BcdW-1:0]        bcd_q, bcd_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [BcdW-1:0]        adj;
  logic [BcdW-1:0]        shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Binary MSB enters the ones digit; the top scratch bit is dropped.
  assign shifted = {adj[BcdW-2:0], bin_q[INPUT_WIDTH-1]};

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          bin_d   = bus.data_in;
          scr_d   = '0;
          cnt_d   = CntW'(INPUT_WIDTH);
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        scr_d = shifted;
        bin_d = {bin_q[INPUT_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          bcd_d   = shifted;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule
